// File: rtl/mnist_dlayer_unpack.sv
// mnist_dlayer_unpack: packed dense-layer vector to oldest-first word stream.
// Optional ReLU on each emitted word when MNIST_UNPACK_RELU_EN is defined.
module mnist_dlayer_unpack #(
    parameter int NWORDS = 20,
    parameter int WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NWORDS*WIDTH-1:0] din,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        dout,
    output logic [4:0]              out_idx,
    output logic                    out_last
);

    localparam int         TOTAL    = NWORDS * WIDTH;
    localparam logic [4:0] LAST_IDX = 5'(NWORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e             state_q, state_d;
    logic [TOTAL-1:0]   sreg_q, sreg_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [4:0]         idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;

    // Word conditioning applied as a word is loaded into dout.
    function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] w);
`ifdef MNIST_UNPACK_RELU_EN
        return w[WIDTH-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    // Next-state: accept a vector in IDLE, step through words in SEND.
    // sreg always holds the not-yet-emitted words with the next one at bit 0.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        dout_d   = dout_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        last_d   = last_q;
        in_ready = (state_q == IDLE);
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = {{WIDTH{1'b0}}, din[TOTAL-1:WIDTH]};
                    dout_d  = relu(din[WIDTH-1:0]);
                    idx_d   = '0;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (valid_q && out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        dout_d = relu(sreg_q[WIDTH-1:0]);
                        sreg_d = {{WIDTH{1'b0}}, sreg_q[TOTAL-1:WIDTH]};
                        idx_d  = idx_q + 5'd1;
                        last_d = ((idx_q + 5'd1) == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            dout_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            dout_q  <= dout_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign dout      = dout_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_mnist_dlayer_unpack.sv
// Testbench for mnist_dlayer_unpack: table-driven handshake vectors
// plus hand-written reset and stall sequences.
module tb_mnist_dlayer_unpack;

    localparam int NW = 20;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [NW*W-1:0] din;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    dout;
    logic [4:0]      out_idx;
    logic            out_last;

    int checks = 0;
    int errors = 0;

    mnist_dlayer_unpack #(.NWORDS(NW), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        ordy;
        int          sel;
        logic        ev;
        logic [31:0] ed;
        logic [4:0]  ei;
        logic        el;
        logic        eir;
    } vec_t;

    vec_t vecs[$];

    // Vector 0: 0x100+k. Vector 1: signed corner words then 0x200+k.
    function automatic logic [31:0] raw(input int sel, input int k);
        if (sel == 0) return 32'(32'h100 + k);
        if (k == 0) return 32'h8000_0001;
        if (k == 1) return 32'hFFFF_FFFF;
        if (k == 2) return 32'h0000_0005;
        return 32'(32'h200 + k);
    endfunction

    function automatic logic [31:0] ew(input int sel, input int k);
        logic [31:0] r;
        r = raw(sel, k);
`ifdef MNIST_UNPACK_RELU_EN
        if (r[31]) r = 32'h0;
`endif
        return r;
    endfunction

    function automatic logic [NW*W-1:0] vec(input int sel);
        logic [NW*W-1:0] v;
        for (int k = 0; k < NW; k++) v[k*W +: W] = raw(sel, k);
        return v;
    endfunction

    task automatic add(input logic iv, input logic ordy, input int sel,
                       input logic ev, input logic [31:0] ed,
                       input int ei, input logic el, input logic eir);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.sel = sel;
        v.ev = ev; v.ed = ed; v.ei = 5'(ei); v.el = el; v.eir = eir;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev,
                           input logic [31:0] ed, input logic [4:0] ei,
                           input logic el, input logic eir);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, " dout"}, dout, ed);
        chk({tag, " out_idx"}, 32'(out_idx), 32'(ei));
        chk({tag, " out_last"}, 32'(out_last), 32'(el));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(eir));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int i;
        // Frame A with out_ready high: 20 words, then idle.
        add(1, 1, 0, 1, ew(0, 0), 0, 0, 0);
        for (int k = 1; k < NW; k++)
            add(0, 1, 0, 1, ew(0, k), k, k == NW - 1, 0);
        add(0, 1, 0, 0, ew(0, NW - 1), 0, 0, 1);
        // Frame A with out_ready toggling 1,0,1,0: 39 cycles.
        add(1, 1, 0, 1, ew(0, 0), 0, 0, 0);
        i = 0;
        for (int j = 0; j < 39; j++) begin
            logic r;
            r = (j % 2 == 0);
            if (r) i++;
            if (i == NW) add(0, r, 0, 0, ew(0, NW - 1), 0, 0, 1);
            else add(0, r, 0, 1, ew(0, i), i, i == NW - 1, 0);
        end
        // Back-to-back with in_valid held; din switches to B during A.
        add(1, 1, 0, 1, ew(0, 0), 0, 0, 0);
        for (int k = 1; k < NW; k++)
            add(1, 1, 1, 1, ew(0, k), k, k == NW - 1, 0);
        add(1, 1, 1, 0, ew(0, NW - 1), 0, 0, 1);
        add(1, 1, 1, 1, ew(1, 0), 0, 0, 0);
        for (int k = 1; k < NW; k++)
            add(0, 1, 0, 1, ew(1, k), k, k == NW - 1, 0);
        add(0, 1, 0, 0, ew(1, NW - 1), 0, 0, 1);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
        repeat (2) step();
        chk_all("reset", 0, 32'h0, 5'd0, 0, 1);
        rst_n = 1'b1;
        step();
        chk_all("post-reset idle", 0, 32'h0, 5'd0, 0, 1);

        foreach (vecs[n]) begin
            in_valid  = vecs[n].iv;
            out_ready = vecs[n].ordy;
            din       = vec(vecs[n].sel);
            step();
            chk_all($sformatf("vec%0d", n), vecs[n].ev, vecs[n].ed,
                    vecs[n].ei, vecs[n].el, vecs[n].eir);
        end

        // Explicit signed-word checks on a fresh frame B.
        in_valid = 1'b1; out_ready = 1'b0; din = vec(1);
        step();
        in_valid = 1'b0;
`ifdef MNIST_UNPACK_RELU_EN
        chk("relu w0", dout, 32'h0);
`else
        chk("pass w0", dout, 32'h8000_0001);
`endif
        step();
        chk("stall hold dout", dout, ew(1, 0));
        chk("stall hold idx", 32'(out_idx), 32'd0);
        out_ready = 1'b1;
        step();
`ifdef MNIST_UNPACK_RELU_EN
        chk("relu w1", dout, 32'h0);
`else
        chk("pass w1", dout, 32'hFFFF_FFFF);
`endif
        step();
        chk("w2", dout, 32'h5);
        repeat (NW - 2) step();
        chk("frame B end", 32'(out_valid), 32'd0);

        // Mid-frame reset after word 7 transfers.
        in_valid = 1'b1; out_ready = 1'b1; din = vec(0);
        step();
        in_valid = 1'b0;
        repeat (8) step();
        chk_all("before mid reset", 1, 32'h108, 5'd8, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_all("mid reset", 0, 32'h0, 5'd0, 0, 1);
        step();
        rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b0; din = vec(0);
        step();
        in_valid = 1'b0;
        chk_all("reload w0", 1, 32'h100, 5'd0, 0, 0);
        out_ready = 1'b1;
        step();
        chk_all("reload w1", 1, 32'h101, 5'd1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
